regfile_operand_stage: RTL and testbench



---
 rtl/regfile_operand_stage_pkg.sv | 20 ++
 rtl/regfile_operand_stage_regfile8x16.sv | 29 ++
 rtl/regfile_operand_stage.sv | 103 ++++++++++
 tb/tb_regfile_operand_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_operand_stage_pkg.sv
// Shared types and constants for the operand-fetch stage and its register file.
package regfile_operand_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_N  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ_A = 2'd1,
    ST_READ_B = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Shift codes forwarded untouched to the shifter.
  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/regfile_operand_stage_regfile8x16.sv
// General register file: one synchronous write port, one combinational read port.
module regfile8x16 #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [$clog2(REG_N)-1:0]   writenum,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [$clog2(REG_N)-1:0]   read_idx,
  output logic [DATA_W-1:0]          read_data
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign read_data = regs[read_idx];

endmodule

// File: rtl/regfile_operand_stage.sv
// Fetches two source registers over consecutive cycles and presents them as a
// frozen A/B operand pair with the shift code under a valid/ready handshake.
module regfile_operand_stage #(
  parameter int DATA_W = regfile_operand_stage_pkg::DATA_W,
  parameter int REG_N  = regfile_operand_stage_pkg::REG_N
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(REG_N)-1:0]   rn,
  input  logic [$clog2(REG_N)-1:0]   rm,
  input  logic [1:0]                 shift_in,
  input  logic                       write,
  input  logic [$clog2(REG_N)-1:0]   writenum,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          a_out,
  output logic [DATA_W-1:0]          b_out,
  output logic [1:0]                 shift_out,
  output logic                       out_valid,
  output logic                       busy
);

  import regfile_operand_stage_pkg::*;

  localparam int IDX_W = $clog2(REG_N);

  state_t             state;
  logic [IDX_W-1:0]   rn_q;
  logic [IDX_W-1:0]   rm_q;
  logic [1:0]         shift_q;
  logic [IDX_W-1:0]   read_idx;
  logic [DATA_W-1:0]  read_data;
  logic [DATA_W-1:0]  operand;

  regfile8x16 #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .read_idx  (read_idx),
    .read_data (read_data)
  );

  // The single read port serves rn in READ_A and rm in READ_B; a same-edge
  // write to the index being read is forwarded so the operand is never stale.
  assign read_idx = (state == ST_READ_B) ? rm_q : rn_q;
  assign operand  = (write && (writenum == read_idx)) ? data_in : read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rn_q      <= '0;
      rm_q      <= '0;
      shift_q   <= SH_PASS;
      a_out     <= '0;
      b_out     <= '0;
      shift_out <= SH_PASS;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rn_q    <= rn;
            rm_q    <= rm;
            shift_q <= shift_in;
            state   <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          a_out <= operand;
          state <= ST_READ_B;
        end
        ST_READ_B: begin
          b_out     <= operand;
          shift_out <= shift_q;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          // Operands stay frozen until the handshake; start on that edge chains the next command.
          if (out_ready) begin
            if (start) begin
              rn_q    <= rn;
              rm_q    <= rm;
              shift_q <= shift_in;
              state   <= ST_READ_A;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Randomized self-checking bench for regfile_operand_stage against a register-array model.
module tb_regfile_operand_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  rn = '0;
  logic [2:0]  rm = '0;
  logic [1:0]  shift_in = '0;
  logic        write = 1'b0;
  logic [2:0]  writenum = '0;
  logic [15:0] data_in = '0;
  logic        out_ready = 1'b0;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [1:0]  shift_out;
  logic        out_valid;
  logic        busy;

  int total = 0;
  int bad = 0;

  // Model: register contents as seen just after each clock edge.
  logic [15:0] mregs [8];
  logic [15:0] exp_a;
  logic [15:0] exp_b;
  logic [1:0]  exp_sh;

  regfile_operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rn        (rn),
    .rm        (rm),
    .shift_in  (shift_in),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    if (write && !reset) mregs[writenum] = data_in;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    write = 1'b1; writenum = idx; data_in = val;
    tick();
    write = 1'b0;
  endtask

  // Issues one command from IDLE or HOLD and checks the fetch up to the first HOLD cycle.
  task automatic run_fetch(input string tag, input logic [2:0] a_idx, input logic [2:0] b_idx,
                           input logic [1:0] sh, input bit rnd_wr, input bit noisy_start,
                           input bit force_b, input logic [2:0] f_idx, input logic [15:0] f_data);
    start = 1'b1; rn = a_idx; rm = b_idx; shift_in = sh; out_ready = 1'b1; write = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL %s read_a_state busy/valid got=%0b%0b want=10", tag, busy, out_valid);
    end
    start = noisy_start; rn = 3'($urandom); rm = 3'($urandom); shift_in = 2'($urandom);
    out_ready = 1'($urandom);
    if (rnd_wr) begin
      write = 1'($urandom); writenum = ($urandom % 2 == 0) ? a_idx : 3'($urandom);
      data_in = 16'($urandom);
    end
    tick();
    exp_a = mregs[a_idx];
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL %s read_b_state busy/valid got=%0b%0b want=10", tag, busy, out_valid);
    end
    total++;
    if (a_out !== exp_a) begin
      bad++; $display("FAIL %s a_load got=%h want=%h", tag, a_out, exp_a);
    end
    start = noisy_start; rn = 3'($urandom); rm = 3'($urandom); write = 1'b0;
    if (rnd_wr) begin
      write = 1'($urandom); writenum = ($urandom % 2 == 0) ? b_idx : 3'($urandom);
      data_in = 16'($urandom);
    end
    if (force_b) begin
      write = 1'b1; writenum = f_idx; data_in = f_data;
    end
    tick();
    exp_b = mregs[b_idx];
    exp_sh = sh;
    write = 1'b0; start = 1'b0; out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL %s hold_valid busy/valid got=%0b%0b want=11", tag, busy, out_valid);
    end
    total++;
    if (a_out !== exp_a || b_out !== exp_b || shift_out !== exp_sh) begin
      bad++;
      $display("FAIL %s operands got=%h/%h/%b want=%h/%h/%b", tag, a_out, b_out, shift_out,
               exp_a, exp_b, exp_sh);
    end
  endtask

  // Stalls in HOLD with random writes, then optionally completes the handshake to IDLE.
  task automatic release_hold(input string tag, input int stall, input bit go_idle);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0; start = 1'($urandom);
      write = 1'b1; writenum = 3'($urandom); data_in = 16'($urandom);
      tick();
      total++;
      if (out_valid !== 1'b1 || a_out !== exp_a || b_out !== exp_b || shift_out !== exp_sh) begin
        bad++;
        $display("FAIL %s stall%0d got=%0b %h/%h/%b want=1 %h/%h/%b", tag, i, out_valid,
                 a_out, b_out, shift_out, exp_a, exp_b, exp_sh);
      end
    end
    write = 1'b0; start = 1'b0;
    if (go_idle) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        bad++; $display("FAIL %s to_idle busy/valid got=%0b%0b want=00", tag, busy, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    clear_model();
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%h/%b/%0b/%0b want=0000/0000/00/0/0", a_out, b_out,
               shift_out, out_valid, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    write_reg(3'd3, 16'h00A5);
    write_reg(3'd5, 16'h1234);
    run_fetch("basic", 3'd3, 3'd5, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    total++;
    if (a_out !== 16'h00A5 || b_out !== 16'h1234) begin
      bad++; $display("FAIL basic_const got=%h/%h want=00a5/1234", a_out, b_out);
    end
    release_hold("basic", 0, 1'b1);
  endtask

  task automatic test_bypass();
    run_fetch("bypass", 3'd2, 3'd4, 2'b10, 1'b0, 1'b0, 1'b1, 3'd4, 16'hBEEF);
    total++;
    if (b_out !== 16'hBEEF) begin
      bad++; $display("FAIL bypass_b got=%h want=beef", b_out);
    end
    release_hold("bypass", 0, 1'b1);
  endtask

  task automatic test_stall_back_to_back();
    write_reg(3'd3, 16'h00A5);
    run_fetch("stall", 3'd3, 3'd5, 2'b11, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0; write = 1'b1; writenum = 3'd3; data_in = 16'hFFFF;
      tick();
      total++;
      if (a_out !== 16'h00A5 || out_valid !== 1'b1) begin
        bad++; $display("FAIL stall_frozen%0d got=%h/%0b want=00a5/1", i, a_out, out_valid);
      end
    end
    write = 1'b0;
    run_fetch("b2b", 3'd5, 3'd3, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    total++;
    if (a_out !== 16'h1234 || b_out !== 16'hFFFF) begin
      bad++; $display("FAIL b2b_const got=%h/%h want=1234/ffff", a_out, b_out);
    end
    release_hold("b2b", 0, 1'b1);
  endtask

  task automatic test_ignored_start();
    run_fetch("ignstart", 3'd1, 3'd6, 2'b01, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    release_hold("ignstart", 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL ignstart_idle%0d busy/valid got=%0b%0b want=00", i, busy, out_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_fetch("rand", 3'($urandom), 3'($urandom), 2'($urandom), 1'b1, 1'($urandom), 1'b0, 3'd0, 16'h0);
      release_hold("rand", $urandom_range(0, 3), (i == 29) || ($urandom % 2 == 0));
    end
  endtask

  task automatic test_async_reset();
    write_reg(3'd3, 16'h0F0F);
    write_reg(3'd5, 16'h5A5A);
    start = 1'b1; rn = 3'd3; rm = 3'd5; shift_in = 2'b11;
    tick();
    start = 1'b0;
    tick();
    total++;
    if (a_out !== 16'h0F0F) begin
      bad++; $display("FAIL areset_pre got=%h want=0f0f", a_out);
    end
    #2 reset = 1'b1;
    #1;
    clear_model();
    total++;
    if (a_out !== 16'h0 || b_out !== 16'h0 || shift_out !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL areset_now got=%h/%h/%b/%0b/%0b want=0000/0000/00/0/0", a_out, b_out,
               shift_out, out_valid, busy);
    end
    #1 reset = 1'b0;
    run_fetch("areset", 3'd3, 3'd5, 2'b01, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    total++;
    if (a_out !== 16'h0 || b_out !== 16'h0) begin
      bad++; $display("FAIL areset_regs got=%h/%h want=0000/0000", a_out, b_out);
    end
    release_hold("areset", 0, 1'b1);
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_bypass();
    test_stall_back_to_back();
    test_ignored_start();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
